// File: rtl/cache_nway.sv
// cache_nway: blocking, write-back, write-allocate set-associative cache.
// Replacement picks the lowest-numbered invalid way first. If every way is
// valid it uses a per-set round-robin pointer. Uncached requests go straight
// to the bridge and never touch the arrays.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   valid/op/uncached/addr/         CPU request (op: 1=store, 0=load)
//   wstrb/wdata
//   addr_ok, data_ok, rdata         CPU handshake and load data
//   rd_req/rd_type/rd_addr/rd_rdy   bridge read request
//   ret_valid/ret_last/ret_data     bridge read return beats
//   wr_req/wr_type/wr_addr/         bridge write request (line or word)
//   wr_wstrb/wr_data/wr_rdy
module cache_nway #(
    parameter int WAYS     = 2,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               valid,
    input  logic                               op,
    input  logic                               uncached,
    input  logic [31:0]                        addr,
    input  logic [3:0]                         wstrb,
    input  logic [31:0]                        wdata,
    output logic                               addr_ok,
    output logic                               data_ok,
    output logic [31:0]                        rdata,
    output logic                               rd_req,
    output logic [2:0]                         rd_type,
    output logic [31:0]                        rd_addr,
    input  logic                               rd_rdy,
    input  logic                               ret_valid,
    input  logic                               ret_last,
    input  logic [31:0]                        ret_data,
    output logic                               wr_req,
    output logic [2:0]                         wr_type,
    output logic [31:0]                        wr_addr,
    output logic [3:0]                         wr_wstrb,
    output logic [32*(1<<(OFFSET_W-2))-1:0]    wr_data,
    input  logic                               wr_rdy
);
    localparam int SETS       = 1 << INDEX_W;
    localparam int LINE_WORDS = 1 << (OFFSET_W - 2);
    localparam int TAG_W      = 32 - INDEX_W - OFFSET_W;
    localparam int WOFF_W     = OFFSET_W - 2;
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WBACK, S_REFILL_REQ, S_REFILL, S_UNC_WR
    } state_t;

    state_t r_state, w_state_next;

    // Latched request
    logic              r_op, r_unc;
    logic [31:0]       r_addr, r_wdata;
    logic [3:0]        r_wstrb;
    logic [WAY_W-1:0]  r_victim;
    logic              r_by_ptr;    // victim came from the round-robin pointer
    logic [WOFF_W-1:0] r_cnt;

    // Storage arrays
    logic [TAG_W-1:0] r_tag   [WAYS][SETS];
    logic [31:0]      r_data  [WAYS][SETS][LINE_WORDS];
    logic [SETS-1:0]  r_valid [WAYS];
    logic [SETS-1:0]  r_dirty [WAYS];
    logic [WAY_W-1:0] r_rr    [SETS];

    logic [INDEX_W-1:0]          w_idx;
    logic [TAG_W-1:0]            w_tag;
    logic [WOFF_W-1:0]           w_woff;
    logic [WAYS-1:0]             w_hit;
    logic                        w_hit_any;
    logic [WAY_W-1:0]            w_hit_way;
    logic                        w_inv_any;
    logic [WAY_W-1:0]            w_inv_way;
    logic [WAY_W-1:0]            w_victim;
    logic                        w_victim_dirty;
    logic [32*LINE_WORDS-1:0]    w_line;

    assign w_idx  = r_addr[OFFSET_W +: INDEX_W];
    assign w_tag  = r_addr[31 -: TAG_W];
    assign w_woff = r_addr[OFFSET_W-1:2];

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++)
            m[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        return m;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_hit
            assign w_hit[gi] = r_valid[gi][w_idx] && (r_tag[gi][w_idx] == w_tag);
        end
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_line
            assign w_line[gi*32 +: 32] = r_data[r_victim][w_idx][gi];
        end
    endgenerate

    always_comb begin
        w_hit_way = '0;
        w_inv_any = 1'b0;
        w_inv_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (w_hit[w]) w_hit_way = WAY_W'(w);
        // Scan downwards so the lowest-numbered invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--)
            if (!r_valid[w][w_idx]) begin
                w_inv_any = 1'b1;
                w_inv_way = WAY_W'(w);
            end
    end

    assign w_hit_any      = |w_hit;
    assign w_victim       = w_inv_any ? w_inv_way : ((WAYS == 1) ? '0 : r_rr[w_idx]);
    assign w_victim_dirty = r_valid[w_victim][w_idx] & r_dirty[w_victim][w_idx];

    // Next state and outputs
    always_comb begin
        w_state_next = r_state;
        addr_ok  = 1'b0;
        data_ok  = 1'b0;
        rdata    = '0;
        rd_req   = 1'b0;
        rd_type  = 3'b000;
        rd_addr  = '0;
        wr_req   = 1'b0;
        wr_type  = 3'b000;
        wr_addr  = '0;
        wr_wstrb = 4'h0;
        wr_data  = '0;
        case (r_state)
            S_IDLE: begin
                addr_ok = 1'b1;
                if (valid)
                    w_state_next = !uncached ? S_LOOKUP : (op ? S_UNC_WR : S_REFILL_REQ);
            end
            S_LOOKUP: begin
                if (w_hit_any) begin
                    data_ok      = 1'b1;
                    rdata        = r_op ? 32'h0 : r_data[w_hit_way][w_idx][w_woff];
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = w_victim_dirty ? S_WBACK : S_REFILL_REQ;
                end
            end
            S_WBACK: begin
                wr_req   = 1'b1;
                wr_type  = 3'b100;
                wr_addr  = {r_tag[r_victim][w_idx], w_idx, {OFFSET_W{1'b0}}};
                wr_wstrb = 4'hf;
                wr_data  = w_line;
                if (wr_rdy) w_state_next = S_REFILL_REQ;
            end
            S_REFILL_REQ: begin
                rd_req  = 1'b1;
                rd_type = r_unc ? 3'b010 : 3'b100;
                rd_addr = r_unc ? r_addr : {w_tag, w_idx, {OFFSET_W{1'b0}}};
                if (rd_rdy) w_state_next = S_REFILL;
            end
            S_REFILL: begin
                if (ret_valid) begin
                    if (r_unc) begin
                        data_ok      = 1'b1;
                        rdata        = ret_data;
                        w_state_next = S_IDLE;
                    end else begin
                        // Loads complete on the critical word, stores on the last beat.
                        if (!r_op && r_cnt == w_woff) begin
                            data_ok = 1'b1;
                            rdata   = ret_data;
                        end
                        if (ret_last) begin
                            if (r_op) data_ok = 1'b1;
                            w_state_next = S_IDLE;
                        end
                    end
                end
            end
            S_UNC_WR: begin
                wr_req   = 1'b1;
                wr_type  = 3'b010;
                wr_addr  = r_addr;
                wr_wstrb = r_wstrb;
                wr_data  = {{(32*LINE_WORDS-32){1'b0}}, r_wdata};
                if (wr_rdy) begin
                    data_ok      = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (reset) begin
            w_state_next = S_IDLE;
            addr_ok = 1'b0;
            data_ok = 1'b0;
            rdata   = '0;
            rd_req  = 1'b0;
            wr_req  = 1'b0;
        end
    end

    // Control state, valid/dirty bits and replacement pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= 1'b0;
            r_unc    <= 1'b0;
            r_addr   <= '0;
            r_wstrb  <= '0;
            r_wdata  <= '0;
            r_victim <= '0;
            r_by_ptr <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
                r_dirty[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: if (valid) begin
                    r_op    <= op;
                    r_unc   <= uncached;
                    r_addr  <= addr;
                    r_wstrb <= wstrb;
                    r_wdata <= wdata;
                end
                S_LOOKUP: begin
                    if (w_hit_any) begin
                        if (r_op) r_dirty[w_hit_way][w_idx] <= 1'b1;
                    end else begin
                        r_victim <= w_victim;
                        r_by_ptr <= !w_inv_any && (WAYS > 1);
                    end
                end
                S_WBACK: if (wr_rdy) r_dirty[r_victim][w_idx] <= 1'b0;
                S_REFILL: if (ret_valid && !r_unc) begin
                    r_cnt <= ret_last ? '0 : r_cnt + 1'b1;
                    if (ret_last) begin
                        r_valid[r_victim][w_idx] <= 1'b1;
                        r_dirty[r_victim][w_idx] <= r_op;
                        if (r_by_ptr) r_rr[w_idx] <= r_rr[w_idx] + WAY_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays: contents are don't-care until the valid bit is set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == S_LOOKUP && w_hit_any && r_op)
                r_data[w_hit_way][w_idx][w_woff] <=
                    merge(r_data[w_hit_way][w_idx][w_woff], r_wdata, r_wstrb);
            if (r_state == S_REFILL && ret_valid && !r_unc) begin
                r_data[r_victim][w_idx][r_cnt] <= (r_op && r_cnt == w_woff) ?
                    merge(ret_data, r_wdata, r_wstrb) : ret_data;
                if (ret_last) r_tag[r_victim][w_idx] <= w_tag;
            end
        end
    end
endmodule
